// File: rtl/vector_lsu_if.sv
// OBI-style data memory port between the vector LSU (master) and data memory (slave).
interface vector_lsu_if #(
    parameter int AW = 32
);
    logic          data_req;
    logic          data_gnt;
    logic [AW-1:0] data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_wdata;
    logic          data_rvalid;
    logic [31:0]   data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store unit: walks up to vl elements, one memory transaction per element.
// Define VLSU_STRIDE_EN to honour the byte stride; otherwise elements are unit-strided.
module vector_lsu #(
    parameter int VLEN = 128,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            start,
    input  logic            store,
    input  logic [AW-1:0]   base_addr,
    input  logic [31:0]     stride,
    input  logic [4:0]      vl,
    input  logic [1:0]      vsew,
    input  logic [VLEN-1:0] vs3_data,
    vector_lsu_if.master    mem,
    output logic            busy,
    output logic            done,
    output logic            misaligned,
    output logic [VLEN-1:0] load_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [4:0]      idx_q, idx_d, n_q, n_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      sew_q, sew_d;
    logic            store_q, store_d, mis_q, mis_d;
    logic [VLEN-1:0] vs3_q, vs3_d, load_q, load_d;
    logic [AW-1:0]   step;
    logic [4:0]      n_start;
    int              lim;
    logic            elem_mis;
    logic [31:0]     rdata_sh, st_elem;
    logic [3:0]      be_base;

`ifdef VLSU_STRIDE_EN
    logic [AW-1:0] stride_q;
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                       stride_q <= '0;
        else if (state_q == IDLE && start)  stride_q <= AW'($signed(stride));
    end
    assign step = stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^stride;
    assign step = AW'(1) << sew_q;
`endif

    // Element count is clamped to what fits in one vector register.
    always_comb begin
        lim = 0;
        unique case (vsew)
            2'd0: lim = VLEN / 8;
            2'd1: lim = VLEN / 16;
            2'd2: lim = VLEN / 32;
            2'd3: lim = 0;
        endcase
        n_start = (int'(vl) < lim) ? vl : 5'(lim);
    end

    assign elem_mis = (sew_q == 2'd1 && addr_q[0]) ||
                      (sew_q == 2'd2 && addr_q[1:0] != 2'b00);
    assign rdata_sh = mem.data_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        st_elem = '0;
        be_base = '0;
        unique case (sew_q)
            2'd0: begin st_elem[7:0]  = vs3_q[int'(idx_q)*8 +: 8];   be_base = 4'b0001; end
            2'd1: begin st_elem[15:0] = vs3_q[int'(idx_q)*16 +: 16]; be_base = 4'b0011; end
            default: begin st_elem    = vs3_q[int'(idx_q)*32 +: 32]; be_base = 4'b1111; end
        endcase
    end

    // Request fields are decoded from registered state only, so they hold steady until the grant.
    always_comb begin
        mem.data_req   = 1'b0;
        mem.data_addr  = '0;
        mem.data_we    = 1'b0;
        mem.data_be    = '0;
        mem.data_wdata = '0;
        if (state_q == REQ && !elem_mis) begin
            mem.data_req   = 1'b1;
            mem.data_addr  = {addr_q[AW-1:2], 2'b00};
            mem.data_we    = store_q;
            mem.data_be    = be_base << addr_q[1:0];
            mem.data_wdata = st_elem << {addr_q[1:0], 3'b000};
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign misaligned = (state_q == DONE) && mis_q;
    assign load_data  = load_q;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        addr_d  = addr_q;
        sew_d   = sew_q;
        store_d = store_q;
        mis_d   = mis_q;
        vs3_d   = vs3_q;
        load_d  = load_q;
        unique case (state_q)
            IDLE: if (start) begin
                load_d = '0;
                mis_d  = (vsew == 2'd3);
                if (vsew == 2'd3 || n_start == 5'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                    idx_d   = '0;
                    n_d     = n_start;
                    addr_d  = base_addr;
                    sew_d   = vsew;
                    store_d = store;
                    vs3_d   = vs3_data;
                end
            end
            REQ: begin
                if (elem_mis) begin
                    mis_d   = 1'b1;
                    state_d = DONE;
                end else if (mem.data_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: if (mem.data_rvalid) begin
                if (!store_q) begin
                    unique case (sew_q)
                        2'd0:    load_d[int'(idx_q)*8 +: 8]   = rdata_sh[7:0];
                        2'd1:    load_d[int'(idx_q)*16 +: 16] = rdata_sh[15:0];
                        default: load_d[int'(idx_q)*32 +: 32] = rdata_sh;
                    endcase
                end
                idx_d   = idx_q + 5'd1;
                addr_d  = addr_q + step;
                state_d = (idx_d == n_q) ? DONE : REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            sew_q   <= '0;
            store_q <= 1'b0;
            mis_q   <= 1'b0;
            vs3_q   <= '0;
            // NOTE: the result register is reset because load_data is architecturally visible after reset.
            load_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            sew_q   <= sew_d;
            store_q <= store_d;
            mis_q   <= mis_d;
            vs3_q   <= vs3_d;
            load_q  <= load_d;
        end
    end
endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: directed operations against a behavioural
// element-walk model, with a memory responder that can stall grant and response.
`timescale 1ns/1ps
module tb_vector_lsu;
    localparam int VLEN = 128;
    localparam int AW   = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic            clk = 1'b0;
    logic            n_reset = 1'b0;
    logic            start = 1'b0, store = 1'b0;
    logic [31:0]     base_addr = '0, stride = '0;
    logic [4:0]      vl = '0;
    logic [1:0]      vsew = '0;
    logic [VLEN-1:0] vs3_data = '0;
    logic            busy, done, misaligned;
    logic [VLEN-1:0] load_data;

    vector_lsu_if #(.AW(AW)) mem_if ();

    vector_lsu #(.VLEN(VLEN), .AW(AW)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (start),
        .store     (store),
        .base_addr (base_addr),
        .stride    (stride),
        .vl        (vl),
        .vsew      (vsew),
        .vs3_data  (vs3_data),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .misaligned(misaligned),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- memory ----------------
    logic [31:0] mem_words [logic [31:0]];
    int          gnt_dly = 0, rv_dly = 0;
    bit          r_pend = 0;
    int          r_wcnt = 0, r_rcnt = 0;
    logic [31:0] r_buf = '0, w_buf = '0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem_words.exists(a) ? mem_words[a] : 32'h0;
    endfunction

    initial begin
        mem_if.data_gnt    = 1'b0;
        mem_if.data_rvalid = 1'b0;
        mem_if.data_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_if.data_gnt    = 1'b0;
            mem_if.data_rvalid = 1'b0;
            mem_if.data_rdata  = 32'hDEAD_BEEF;
            if (r_pend) begin
                if (r_rcnt == 0) begin
                    mem_if.data_rvalid = 1'b1;
                    mem_if.data_rdata  = r_buf;
                    r_pend = 0;
                end else r_rcnt--;
            end else if (mem_if.data_req && n_reset) begin
                if (r_wcnt >= gnt_dly) begin
                    mem_if.data_gnt = 1'b1;
                    r_wcnt = 0;
                    r_pend = 1;
                    r_rcnt = rv_dly;
                    r_buf  = rd_word(mem_if.data_addr);
                    if (mem_if.data_we) begin
                        w_buf = r_buf;
                        for (int b = 0; b < 4; b++)
                            if (mem_if.data_be[b]) w_buf[8*b +: 8] = mem_if.data_wdata[8*b +: 8];
                        mem_words[mem_if.data_addr] = w_buf;
                    end
                end else r_wcnt++;
            end
        end
    end

    // ---------------- model ----------------
    txn_t            exp_q[$];
    logic [VLEN-1:0] exp_load = '0;
    logic            exp_mis = 1'b0;
    logic            exp_busy = 1'b0;
    int              gnt_cnt = 0;

    // Walks the elements from the operation's rules and lists the transactions it must see.
    task automatic build_expect(input logic st, input logic [31:0] base, input logic [31:0] strd,
                                input int nvl, input int sew, input logic [VLEN-1:0] src,
                                output int n_txn, output int exp_cycle);
        int w, n;
        logic [31:0] a, step, elem, word;
        txn_t t;
        exp_q.delete();
        exp_load = '0;
        exp_mis  = 1'b0;
        n_txn    = 0;
        if (sew == 3) begin
            exp_mis   = 1'b1;
            exp_cycle = 1;
            return;
        end
        w = 8 << sew;
        n = (nvl < VLEN / w) ? nvl : VLEN / w;
`ifdef VLSU_STRIDE_EN
        step = strd;
`else
        step = 32'(w / 8);
`endif
        for (int k = 0; k < n; k++) begin
            a = base + step * 32'(k);
            if (a % 32'(w / 8) != 0) begin
                exp_mis = 1'b1;
                break;
            end
            elem    = 32'((src >> (k * w)) & ((128'd1 << w) - 1));
            t.addr  = a & ~32'h3;
            t.be    = 4'(((1 << (w / 8)) - 1) << (a % 4));
            t.we    = st;
            t.wdata = elem << (8 * (a % 4));
            exp_q.push_back(t);
            n_txn++;
            if (!st) begin
                word = rd_word(a & ~32'h3);
                exp_load |= VLEN'((word >> (8 * (a % 4))) & ((64'd1 << w) - 1)) << (k * w);
            end
        end
        if (n == 0)   exp_cycle = 1;
        else if (exp_mis) exp_cycle = 2 * n_txn + 2;
        else          exp_cycle = 2 * n + 1;
    endtask

    // ---------------- compare process ----------------
    txn_t cur, prev_txn;
    bit   prev_wait = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                prev_wait = 0;
            end else begin
                cur = '{mem_if.data_addr, mem_if.data_be, mem_if.data_we, mem_if.data_wdata};
                check("busy", {127'd0, busy}, {127'd0, exp_busy});
                if (mem_if.data_req) begin
                    if (prev_wait) check("req_stable", 128'(cur), 128'(prev_txn));
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_req", $sformatf("got request to %h, required none", cur.addr));
                    end else begin
                        check("req_addr", 128'(cur.addr), 128'(exp_q[0].addr));
                        check("req_be", 128'(cur.be), 128'(exp_q[0].be));
                        check("req_we", 128'(cur.we), 128'(exp_q[0].we));
                        if (exp_q[0].we) check("req_wdata", 128'(cur.wdata), 128'(exp_q[0].wdata));
                        if (mem_if.data_gnt) begin
                            void'(exp_q.pop_front());
                            gnt_cnt++;
                        end
                    end
                    prev_wait = !mem_if.data_gnt;
                    prev_txn  = cur;
                end else begin
                    if (prev_wait) fail_now("req_dropped", "got request withdrawn before grant, required held");
                    prev_wait = 0;
                end
                check("misaligned", {127'd0, misaligned}, {127'd0, done && exp_mis});
                if (done) begin
                    if (!exp_busy) fail_now("stray_done", "got done while idle, required none");
                    check("load_data", load_data, exp_load);
                    check("txns_left", 128'(exp_q.size()), 128'd0);
                end
                if (start && !exp_busy) exp_busy = 1'b1;
                else if (done)          exp_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic st, input logic [31:0] base, input logic [31:0] strd,
                          input logic [4:0] nvl, input logic [1:0] sew, input logic [VLEN-1:0] src,
                          output int n_txn, output int exp_cycle);
        build_expect(st, base, strd, int'(nvl), int'(sew), src, n_txn, exp_cycle);
        gnt_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1; store = st; base_addr = base; stride = strd;
        vl = nvl; vsew = sew; vs3_data = src;
        @(posedge clk);
        #1;
        // Scramble operands so only latched copies can be used.
        start = 1'b0; store = ~st; base_addr = 32'hFFFF_FFF3; stride = 32'h7;
        vl = 5'd0; vsew = 2'd3; vs3_data = '1;
    endtask

    task automatic run_op(input string tag, input logic st, input logic [31:0] base,
                          input logic [31:0] strd, input logic [4:0] nvl, input logic [1:0] sew,
                          input logic [VLEN-1:0] src, input bit poke,
                          output int cyc, output logic mis_seen);
        int n_txn, exp_cycle;
        logic d;
        launch(st, base, strd, nvl, sew, src, n_txn, exp_cycle);
        cyc = 0;
        mis_seen = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            d = done;
            mis_seen = misaligned;
            if (start) begin #1; start = 1'b0; end
            if (d) begin cyc = c; break; end
            if (poke && (c == 3 || c == 9)) begin #1; start = 1'b1; end
        end
        if (cyc == 0) fail_now({tag, "_timeout"}, "got no done within 400 cycles, required done");
        if (gnt_dly == 0 && rv_dly == 0) check({tag, "_latency"}, 128'(cyc), 128'(exp_cycle));
        check({tag, "_txns"}, 128'(gnt_cnt), 128'(n_txn));
        @(negedge clk);
    endtask

    int   cyc;
    logic mis;
    int   nt, ec;
    bit   seen_done;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required bench finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_words[32'h100] = 32'h4433_2211; mem_words[32'h104] = 32'h8877_6655;
        mem_words[32'h108] = 32'hCCBB_AA99; mem_words[32'h10C] = 32'h00FF_EEDD;
        mem_words[32'h500] = 32'h1111_1111; mem_words[32'h504] = 32'h2222_2222;
        mem_words[32'h508] = 32'h3333_3333; mem_words[32'h50C] = 32'h4444_4444;
        mem_words[32'h300] = 32'h5A5A_1234; mem_words[32'h304] = 32'h0BAD_CAFE;
        mem_words[32'h308] = 32'h7777_8888; mem_words[32'h30C] = 32'h9999_AAAA;
        mem_words[32'h400] = 32'h2222_1111; mem_words[32'h404] = 32'h4444_3333;
        mem_words[32'h408] = 32'h6666_5555; mem_words[32'h410] = 32'h8888_7777;
        mem_words[32'h418] = 32'hAAAA_9999;

        #12;
        check("reset_outputs", 128'({mem_if.data_req, mem_if.data_we, mem_if.data_be, mem_if.data_addr,
                                      mem_if.data_wdata, busy, done, misaligned}), 128'd0);
        check("reset_load", load_data, '0);
        @(posedge clk);
        #2;
        n_reset = 1'b1;

        // Unit-stride 8b load of 16 elements.
        run_op("ld8", 1'b0, 32'h100, 32'd1, 5'd16, 2'd0, '0, 1'b0, cyc, mis);
        check("ld8_word0", 128'(load_data[31:0]), 128'h4433_2211);
        check("ld8_word3", 128'(load_data[127:96]), 128'h00FF_EEDD);
        check("ld8_cycle", 128'(cyc), 128'd33);
        check("ld8_count", 128'(gnt_cnt), 128'd16);

        // 32b store of {D,C,B,A}.
        run_op("st32", 1'b1, 32'h200, 32'd8, 5'd4, 2'd2,
               {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b0, cyc, mis);
        check("st32_a", 128'(rd_word(32'h200)), 128'hAAAA_0001);
`ifdef VLSU_STRIDE_EN
        check("st32_b", 128'(rd_word(32'h208)), 128'hBBBB_0002);
        check("st32_d", 128'(rd_word(32'h218)), 128'hDDDD_0004);
`else
        check("st32_b", 128'(rd_word(32'h204)), 128'hBBBB_0002);
        check("st32_d", 128'(rd_word(32'h20C)), 128'hDDDD_0004);
`endif
        check("st32_cycle", 128'(cyc), 128'd9);

        // Clamp to 4 elements, then tail zeroing.
        run_op("clamp", 1'b0, 32'h500, 32'd4, 5'd9, 2'd2, '0, 1'b0, cyc, mis);
        check("clamp_count", 128'(gnt_cnt), 128'd4);
        run_op("tail", 1'b0, 32'h500, 32'd4, 5'd3, 2'd2, '0, 1'b0, cyc, mis);
        check("tail_upper", 128'(load_data[127:96]), 128'd0);
        check("tail_elem2", 128'(load_data[95:64]), 128'h3333_3333);

        // Misalignment on the first and on a later element.
        run_op("mis0", 1'b0, 32'h301, 32'd2, 5'd4, 2'd1, '0, 1'b0, cyc, mis);
        check("mis0_count", 128'(gnt_cnt), 128'd0);
        check("mis0_pulse", 128'(mis), 128'd1);
        check("mis0_cycle", 128'(cyc), 128'd2);
        check("mis0_load", load_data, '0);
        run_op("mis1", 1'b0, 32'h300, 32'd3, 5'd8, 2'd1, '0, 1'b0, cyc, mis);
        check("mis1_elem0", 128'(load_data[15:0]), 128'h1234);
`ifdef VLSU_STRIDE_EN
        check("mis1_count", 128'(gnt_cnt), 128'd1);
        check("mis1_pulse", 128'(mis), 128'd1);
`else
        check("mis1_count", 128'(gnt_cnt), 128'd8);
        check("mis1_pulse", 128'(mis), 128'd0);
`endif

        // Reserved width and zero length finish at once.
        run_op("sew3", 1'b0, 32'h100, 32'd1, 5'd4, 2'd3, '0, 1'b0, cyc, mis);
        check("sew3_pulse", 128'(mis), 128'd1);
        run_op("vl0", 1'b0, 32'h100, 32'd1, 5'd0, 2'd0, '0, 1'b0, cyc, mis);
        check("vl0_pulse", 128'(mis), 128'd0);
        check("vl0_load", load_data, '0);

        // Stalled grant and response, with start pokes while busy.
        gnt_dly = 3;
        rv_dly  = 2;
        run_op("stall_st", 1'b1, 32'h600, 32'd4, 5'd3, 2'd2,
               {32'h0, 32'h3C3C_0003, 32'h2B2B_0002, 32'h1A1A_0001}, 1'b1, cyc, mis);
        check("stall_st_w0", 128'(rd_word(32'h600)), 128'h1A1A_0001);
        check("stall_st_w2", 128'(rd_word(32'h608)), 128'h3C3C_0003);
        run_op("stall_ld", 1'b0, 32'h106, 32'd1, 5'd3, 2'd0, '0, 1'b1, cyc, mis);
        check("stall_ld_val", 128'(load_data[23:0]), 128'h99_8877);
        gnt_dly = 0;
        rv_dly  = 0;

        // 16b load with stride 8.
        run_op("ld16", 1'b0, 32'h400, 32'd8, 5'd4, 2'd1, '0, 1'b0, cyc, mis);
`ifdef VLSU_STRIDE_EN
        check("ld16_val", 128'(load_data[63:0]), 128'h9999_7777_5555_1111);
`else
        check("ld16_val", 128'(load_data[63:0]), 128'h4444_3333_2222_1111);
`endif

        // Reset while waiting for a response; the late response must be ignored.
        rv_dly = 4;
        launch(1'b0, 32'h400, 32'd8, 5'd4, 2'd1, '0, nt, ec);
        for (int c = 0; c < 20 && gnt_cnt == 0; c++) @(negedge clk);
        if (gnt_cnt == 0) fail_now("rst_grant", "got no grant within 20 cycles, required grant");
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check("rst_outputs", 128'({mem_if.data_req, mem_if.data_we, mem_if.data_be, mem_if.data_addr,
                                    mem_if.data_wdata, busy, done, misaligned}), 128'd0);
        check("rst_load", load_data, '0);
        exp_q.delete();
        exp_busy = 1'b0;
        exp_mis  = 1'b0;
        exp_load = '0;
        @(posedge clk);
        #2;
        n_reset = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("rst_no_done", 128'(seen_done), 128'd0);
        rv_dly = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store unit. It sits between the vector decoder/register file and the core's data memory port, and fills the memory write-back source of the vector register file. On a start pulse it walks up to `vl` elements at a base address with a byte stride, one OBI-style memory transaction per element. For loads it packs the returned elements into a 128-bit `load_data` word for the vector registers. For stores it slices elements out of `vs3_data`.

## Interface
- `VLEN`, default 128: vector register width in bits.
- `AW`, default 32: memory address width.
- `clk` input 1: clock.
- `n_reset` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle request from the decoder; sampled only in IDLE.
- `store` input 1: 1 = store, 0 = load; sampled with `start`.
- `base_addr` input AW: byte address of element 0 (decoder `scalar_operand1`).
- `stride` input 32: signed byte stride (decoder `scalar_operand2`).
- `vl` input 5: element count.
- `vsew` input 2: element width; 0 = 8b, 1 = 16b, 2 = 32b; 3 is reserved.
- `vs3_data` input VLEN: store source register, sampled with `start`.
- `data_req` output 1: memory request.
- `data_gnt` input 1: memory grant.
- `data_addr` output AW: word-aligned address.
- `data_we` output 1: write enable.
- `data_be` output 4: byte enables.
- `data_wdata` output 32: write data, placed in the byte lanes selected by `addr[1:0]`.
- `data_rvalid` input 1: read or write response valid.
- `data_rdata` input 32: read data.
- `busy` output 1: high from the cycle after accepted `start` until `done`.
- `done` output 1: one-cycle completion pulse.
- `misaligned` output 1: one-cycle pulse alongside `done` when the access aborted.
- `load_data` output VLEN: packed load result, valid while `done` is high and held afterwards.

## Operation
- States:
  - IDLE
  - REQ: `data_req` high, waiting for `data_gnt`.
  - WAIT: waiting for `data_rvalid`.
  - DONE: one cycle.
- Element limit: `n = min(vl, VLEN/SEW)`; 16, 8 or 4 elements for SEW 8/16/32.
- `start` handling:
  - `start` with `n == 0` or `vsew == 3`: IDLE→DONE. No memory traffic, `load_data` = 0, and `misaligned` = 1 only for `vsew == 3`.
  - Any other `start` in IDLE: latch all inputs, set element index `i = 0`, current address = `base_addr`, clear `load_data`, go to REQ.
- Alignment check, done in REQ before asserting `data_req`:
  - 16b elements with `addr[0] = 1` are misaligned.
  - 32b elements with `addr[1:0] != 0` are misaligned.
  - A misaligned element goes directly to DONE with `misaligned` = 1. Elements already completed are kept in `load_data`; the rest stay 0.
- REQ: `data_req` = 1, `data_addr` = `{addr[AW-1:2], 2'b00}`, `data_be` = SEW-wide mask shifted by `addr[1:0]`. On `data_gnt` go to WAIT.
- WAIT: on `data_rvalid`:
  - Load: extract the element from `data_rdata` at `addr[1:0]` and write it to `load_data[i*SEW +: SEW]`.
  - Then `i++` and `addr += stride`, wrapping modulo 2^AW.
  - If `i == n` go to DONE, else go to REQ.
- Store: `data_wdata` = element `i` of the latched `vs3_data`, replicated or shifted into the lanes given by `addr[1:0]`. `data_we` = 1 throughout REQ.
- DONE: pulse `done`, then go to IDLE. Tail elements (`i ≥ n`) of `load_data` are 0.
- `start` while not IDLE is ignored.

## Timing
- Reset values: `data_req`, `data_we`, `busy`, `done`, `misaligned` = 0; `data_addr`, `data_be`, `data_wdata`, `load_data` = 0; state = IDLE.
- Reset mid-operation aborts immediately. Any later `data_rvalid` is ignored in IDLE.
- One outstanding transaction at a time. `data_req`, `data_addr`, `data_be`, `data_we` and `data_wdata` are stable from assertion until the `data_gnt` cycle.
- `data_gnt` and `data_rvalid` in the same cycle are not allowed; the response comes at least one cycle after the grant.
- Latency with zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle): `start` at cycle 0, REQ at cycle 1, `done` at cycle `2n+1`.
- Zero-length access: `done` at cycle 1.
- `busy` is low in IDLE and high in REQ, WAIT and DONE.

## Configuration
- `VLSU_STRIDE_EN` defined: `stride` is used as described above.
- `VLSU_STRIDE_EN` undefined:
  - The `stride` port is present but ignored.
  - The address increments by SEW/8 bytes (unit stride).
  - Consecutive aligned elements in the same word still use separate transactions.

## Test plan
- Unit-stride 8b load: `base` = 0x100, `stride` = 1, `vl` = 16; memory word at 0x100 = 0x44332211. Require 16 requests at word addresses 0x100 ×4, 0x104 ×4 and so on, `data_be` = 0001, 0010, 0100, 1000 cycling, `load_data[31:0]` = 0x44332211, and `done` at cycle 33 with zero-wait memory.
- 32b store: `vl` = 4, `base` = 0x200, `stride` = 8, `vs3_data` = {D, C, B, A}. Require writes of A, B, C, D to 0x200, 0x208, 0x210, 0x218 with `data_be` = 1111 and `data_we` = 1.
- Clamp and tail: `vsew` = 2, `vl` = 9. Require exactly 4 transactions; with `vl` = 3 require `load_data[127:96]` = 0.
- Misalignment: 16b load with `base` = 0x301. Require no `data_req`, `done` and `misaligned` on the same cycle, `load_data` = 0. With `base` = 0x300 and `stride` = 3, require 1 transaction, then abort, then `load_data[15:0]` = the loaded value.
- Handshake stalls: `data_gnt` delayed 3 cycles and `data_rvalid` delayed 2 cycles. Require request signals held stable and `start` pulses during `busy` ignored.
- Reset mid-access: drive `n_reset` low while in WAIT. Require all outputs at reset values; a stray `data_rvalid` afterwards causes no `done`. With `VLSU_STRIDE_EN` undefined and `stride` = 8, 16b elements, require addresses stepping by 2.
